// File: rtl/tri_input_skew_pkg.sv
// Shared constants and FSM state type for the triangular-array input skew stage.
package tri_pkg;

    localparam int          TRI_DWIDTH = 32;
    localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

endpackage

// File: rtl/tri_input_skew_delay_line.sv
// Fixed-depth shift register of {valid, data}; synchronous active-low clear to (0, RST_VAL).
module skew_delay_line #(
    parameter int                DEPTH   = 1,
    parameter int                DWIDTH  = 32,
    parameter logic [DWIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data
);

    logic              vld_p [DEPTH];
    logic [DWIDTH-1:0] dat_p [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_p[i] <= 1'b0;
                dat_p[i] <= RST_VAL;
            end
        end else begin
            vld_p[0] <= in_valid;
            dat_p[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i] <= vld_p[i-1];
                dat_p[i] <= dat_p[i-1];
            end
        end
    end

    assign out_valid = vld_p[DEPTH-1];
    assign out_data  = dat_p[DEPTH-1];

endmodule

// File: rtl/tri_input_skew.sv
// Diagonal-wavefront input skew for the triangular systolic array.
// Optional TRI_SKEW_PAD_ONE_EN: column 0 bubble/reset data is 1.0 instead of 0.
module tri_input_skew
    import tri_pkg::*;
#(
    parameter int DWIDTH = TRI_DWIDTH,
    parameter int N      = 4,
    parameter int CW     = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DWIDTH-1:0] in_data,
    input  logic                in_last,
    output logic [N*DWIDTH-1:0] out_data,
    output logic [N-1:0]        out_en,
    output logic                out_last,
    output logic                busy
);

`ifdef TRI_SKEW_PAD_ONE_EN
    localparam logic [DWIDTH-1:0] COL0_PAD = DWIDTH'(FP_ONE);
`else
    localparam logic [DWIDTH-1:0] COL0_PAD = DWIDTH'(FP_ZERO);
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          last_vld, last_dat;

    assign in_ready = (state_q != DRAIN);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = DRAIN;
                        cnt_d   = CW'(N - 1);
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept && in_last) begin
                    state_d = DRAIN;
                    cnt_d   = CW'(N - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                end
                cnt_d = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Column j is j+1 stages deep; non-accept cycles inject a bubble.
    for (genvar j = 0; j < N; j++) begin : g_col
        localparam logic [DWIDTH-1:0] PAD = (j == 0) ? COL0_PAD : DWIDTH'(FP_ZERO);
        skew_delay_line #(
            .DEPTH  (j + 1),
            .DWIDTH (DWIDTH),
            .RST_VAL(PAD)
        ) u_line (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (accept),
            .in_data  (accept ? in_data[j*DWIDTH +: DWIDTH] : PAD),
            .out_valid(out_en[j]),
            .out_data (out_data[j*DWIDTH +: DWIDTH])
        );
    end

    // in_last travels alongside the last column only.
    skew_delay_line #(
        .DEPTH  (N),
        .DWIDTH (1),
        .RST_VAL(1'b0)
    ) u_last (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (accept),
        .in_data  (accept & in_last),
        .out_valid(last_vld),
        .out_data (last_dat)
    );

    assign out_last = last_vld & last_dat & out_en[N-1];

    // busy also covers the cycle the final column leaves, since DRAIN ends one cycle earlier.
    assign busy = (state_q != IDLE) | out_last;

endmodule

// File: tb/tb_tri_input_skew.sv
// Directed table, reset-in-flight sequence and random scoreboard for tri_input_skew (N=4).
module tb_tri_input_skew;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int NT = 28;
    localparam int RN = 320;

    typedef logic [134:0] obs_t;

    typedef struct {
        logic         v;
        logic         l;
        logic [127:0] d;
        logic [3:0]   en;
        logic [127:0] od;
        logic         ol;
        logic         bz;
        logic         rd;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic [N*DW-1:0] in_data = '0;
    logic            in_ready;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_en;
    logic            out_last;
    logic            busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    vec_t tbl [NT];

    always #5 clk = ~clk;

    tri_input_skew #(.DWIDTH(DW), .N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .in_last (in_last),
        .out_data(out_data),
        .out_en  (out_en),
        .out_last(out_last),
        .busy    (busy)
    );

    function automatic logic [127:0] pk(input logic [31:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [31:0] el(input int r, input int j);
        return 32'hA000_0000 | 32'(r << 8) | 32'(j);
    endfunction

    function automatic logic [127:0] rw(input int r);
        return pk(el(r, 0), el(r, 1), el(r, 2), el(r, 3));
    endfunction

    function automatic vec_t mkv(input logic v, l, input logic [127:0] d, input logic [3:0] en,
                                 input logic [127:0] od, input logic ol, bz, rd);
        vec_t x;
        x.v = v; x.l = l; x.d = d; x.en = en; x.od = od; x.ol = ol; x.bz = bz; x.rd = rd;
        return x;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input obs_t exp);
        obs_t act;
        act = {out_en, out_last, busy, in_ready, out_data};
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got en/last/busy/ready/data=%h expected %h", nm, act, exp);
    endtask

    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F4 = 32'h4080_0000;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [127:0] NR = 128'h0;

    logic         h_acc  [RN];
    logic         h_last [RN];
    logic [127:0] h_dat  [RN];

    initial begin
        logic [127:0] r1;
        r1 = pk(F1, F2, F3, F4);
        // Single row with last from IDLE.
        tbl[0]  = mkv(1, 1, r1, 4'b0001, pk(F1, Z, Z, Z), 0, 1, 0);
        tbl[1]  = mkv(0, 0, NR, 4'b0010, pk(Z, F2, Z, Z), 0, 1, 0);
        tbl[2]  = mkv(0, 0, NR, 4'b0100, pk(Z, Z, F3, Z), 0, 1, 0);
        tbl[3]  = mkv(0, 0, NR, 4'b1000, pk(Z, Z, Z, F4), 1, 1, 1);
        tbl[4]  = mkv(0, 0, NR, 4'b0000, NR, 0, 0, 1);
        // Three back-to-back rows.
        tbl[5]  = mkv(1, 0, rw(1), 4'b0001, pk(el(1,0), Z, Z, Z), 0, 1, 1);
        tbl[6]  = mkv(1, 0, rw(2), 4'b0011, pk(el(2,0), el(1,1), Z, Z), 0, 1, 1);
        tbl[7]  = mkv(1, 1, rw(3), 4'b0111, pk(el(3,0), el(2,1), el(1,2), Z), 0, 1, 0);
        tbl[8]  = mkv(0, 0, NR, 4'b1110, pk(Z, el(3,1), el(2,2), el(1,3)), 0, 1, 0);
        tbl[9]  = mkv(0, 0, NR, 4'b1100, pk(Z, Z, el(3,2), el(2,3)), 0, 1, 0);
        tbl[10] = mkv(0, 0, NR, 4'b1000, pk(Z, Z, Z, el(3,3)), 1, 1, 1);
        tbl[11] = mkv(0, 0, NR, 4'b0000, NR, 0, 0, 1);
        // Bubble between two rows.
        tbl[12] = mkv(1, 0, rw(4), 4'b0001, pk(el(4,0), Z, Z, Z), 0, 1, 1);
        tbl[13] = mkv(0, 0, NR, 4'b0010, pk(Z, el(4,1), Z, Z), 0, 1, 1);
        tbl[14] = mkv(1, 1, rw(5), 4'b0101, pk(el(5,0), Z, el(4,2), Z), 0, 1, 0);
        tbl[15] = mkv(0, 0, NR, 4'b1010, pk(Z, el(5,1), Z, el(4,3)), 0, 1, 0);
        tbl[16] = mkv(0, 0, NR, 4'b0100, pk(Z, Z, el(5,2), Z), 0, 1, 0);
        tbl[17] = mkv(0, 0, NR, 4'b1000, pk(Z, Z, Z, el(5,3)), 1, 1, 1);
        tbl[18] = mkv(0, 0, NR, 4'b0000, NR, 0, 0, 1);
        // Row offered during DRAIN is held until the stage is ready.
        tbl[19] = mkv(1, 1, rw(6), 4'b0001, pk(el(6,0), Z, Z, Z), 0, 1, 0);
        tbl[20] = mkv(1, 1, rw(7), 4'b0010, pk(Z, el(6,1), Z, Z), 0, 1, 0);
        tbl[21] = mkv(1, 1, rw(7), 4'b0100, pk(Z, Z, el(6,2), Z), 0, 1, 0);
        tbl[22] = mkv(1, 1, rw(7), 4'b1000, pk(Z, Z, Z, el(6,3)), 1, 1, 1);
        tbl[23] = mkv(1, 1, rw(7), 4'b0001, pk(el(7,0), Z, Z, Z), 0, 1, 0);
        tbl[24] = mkv(0, 0, NR, 4'b0010, pk(Z, el(7,1), Z, Z), 0, 1, 0);
        tbl[25] = mkv(0, 0, NR, 4'b0100, pk(Z, Z, el(7,2), Z), 0, 1, 0);
        tbl[26] = mkv(0, 0, NR, 4'b1000, pk(Z, Z, Z, el(7,3)), 1, 1, 1);
        tbl[27] = mkv(0, 0, NR, 4'b0000, NR, 0, 0, 1);

        // Reset state.
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("reset", {4'b0000, 1'b0, 1'b0, 1'b1, NR});
        rst_n = 1'b1;
        cyc();
        chk("post_reset", {4'b0000, 1'b0, 1'b0, 1'b1, NR});

        for (int i = 0; i < NT; i++) begin
            in_valid = tbl[i].v;
            in_last  = tbl[i].l;
            in_data  = tbl[i].d;
            cyc();
            chk($sformatf("vec%0d", i), {tbl[i].en, tbl[i].ol, tbl[i].bz, tbl[i].rd, tbl[i].od});
        end

        // Reset with two rows in flight.
        in_valid = 1'b1; in_last = 1'b0; in_data = rw(8);
        cyc();
        chk("flight_x", {4'b0001, 1'b0, 1'b1, 1'b1, pk(el(8,0), Z, Z, Z)});
        in_data = rw(9);
        cyc();
        chk("flight_y", {4'b0011, 1'b0, 1'b1, 1'b1, pk(el(9,0), el(8,1), Z, Z)});
        in_valid = 1'b0; in_data = '0;
        rst_n = 1'b0;
        cyc();
        chk("mid_reset", {4'b0000, 1'b0, 1'b0, 1'b1, NR});
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("after_reset%0d", k), {4'b0000, 1'b0, 1'b0, 1'b1, NR});
        end

        // Random traffic against a latency model.
        begin
            int           drain_left;
            logic         loading;
            int           last_in;
            int           last_out;
            logic         iv, il, acc, ol;
            logic [127:0] dat;
            logic [3:0]   en;
            logic [127:0] od;
            drain_left = 0; loading = 1'b0; last_in = 0; last_out = 0;
            for (int t = 0; t < RN; t++) begin
                iv  = (t < RN - 10) ? ($urandom_range(0, 3) != 0) : 1'b0;
                il  = ($urandom_range(0, 3) == 0);
                dat = {$urandom, $urandom, $urandom, $urandom};
                acc = iv & (drain_left == 0);
                h_acc[t]  = acc;
                h_last[t] = acc & il;
                h_dat[t]  = dat;
                if (drain_left > 0) begin
                    drain_left--;
                end else if (acc && il) begin
                    drain_left = N - 1;
                    loading    = 1'b0;
                    last_in++;
                end else if (acc) begin
                    loading = 1'b1;
                end
                in_valid = iv; in_last = il; in_data = dat;
                cyc();
                en = '0; od = '0;
                for (int j = 0; j < N; j++) begin
                    if (t - j >= 0 && h_acc[t-j]) begin
                        en[j] = 1'b1;
                        od[j*DW +: DW] = h_dat[t-j][j*DW +: DW];
                    end
                end
                ol = (t - (N - 1) >= 0) && h_last[t-(N-1)];
                if (out_last) last_out++;
                chk($sformatf("rand%0d", t),
                    {en, ol, loading | (drain_left > 0) | ol, drain_left == 0, od});
            end
            total_cnt++;
            if (last_out == last_in) pass_cnt++;
            else $display("FAIL last_count: got %0d out_last pulses, expected %0d", last_out, last_in);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
